// File: rtl/score_disp_bcd.sv
// Binary score to BCD via a sequential double-dabble engine, scanned onto
// NUM_DIGITS active-low common-anode 7-segment digits with blanking and blink.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for score_valid; display register holds last result
// S_SHIFT | SCORE_W shift-add-3 steps, one score bit per cycle
// S_DONE  | commit accumulator (or all-9s on overflow) to display register
module score_disp_bcd #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCORE_W     = 14,
   parameter int REFRESH_DIV = 65536,
   parameter int BLINK_DIV   = 64
) (
   input  logic                  segclk,
   input  logic                  clr_n,
   input  logic [SCORE_W-1:0]    score,
   input  logic                  score_valid,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  busy,
   output logic                  ovf
);

   localparam int AW = (NUM_DIGITS + 1) * 4;
   localparam int DW = NUM_DIGITS * 4;
   localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(SCORE_W - 1);
   localparam logic [PW-1:0] PRE_TC   = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRM_TC   = FW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [SCORE_W-1:0] sh;
   logic [AW-1:0]      acc;
   logic [AW-1:0]      acc_adj;
   logic [AW-1:0]      acc_shift;
   logic               shout;
   logic               ostk;
   logic [CW-1:0]      cnt;
   logic               pend;
   logic [SCORE_W-1:0] pend_val;
   logic               load;
   logic [SCORE_W-1:0] load_val;
   logic [DW-1:0]      disp;

   logic [PW-1:0]      pre;
   logic [IW-1:0]      idx;
   logic               pre_tc;
   logic               wrap;
   logic [FW-1:0]      fcnt;
   logic               phase;
   logic [3:0]         cur_dig;
   logic               cur_lz;
   logic               zrun;

   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // A strobe landing in S_DONE is the newest value, so it wins over pend_val.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      load_val = score;
      case (state)
         S_IDLE: begin
            if (score_valid) begin
               load     = 1'b1;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt == '0) state_nx = S_DONE;
         end
         S_DONE: begin
            if (score_valid || pend) begin
               load     = 1'b1;
               state_nx = S_SHIFT;
               if (!score_valid) load_val = pend_val;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   always_comb begin
      acc_adj = acc;
      for (int k = 0; k < NUM_DIGITS + 1; k++) begin
         if (acc[k*4 +: 4] >= 4'd5) acc_adj[k*4 +: 4] = acc[k*4 +: 4] + 4'd3;
      end
   end

   assign {shout, acc_shift} = {acc_adj, sh[SCORE_W-1]};

   // ostk catches bits pushed out of the top nibble for narrow NUM_DIGITS.
   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         sh       <= '0;
         acc      <= '0;
         ostk     <= 1'b0;
         cnt      <= '0;
         pend     <= 1'b0;
         pend_val <= '0;
         disp     <= '0;
         ovf      <= 1'b0;
      end else begin
         if (load) begin
            sh   <= load_val;
            acc  <= '0;
            ostk <= 1'b0;
            cnt  <= CNT_LAST;
         end else if (state == S_SHIFT) begin
            sh   <= sh << 1;
            acc  <= acc_shift;
            ostk <= ostk | shout;
            cnt  <= cnt - 1'b1;
         end

         if (state == S_DONE) begin
            if ((acc[AW-1 -: 4] != 4'd0) || ostk) begin
               disp <= {NUM_DIGITS{4'h9}};
               ovf  <= 1'b1;
            end else begin
               disp <= acc[DW-1:0];
               ovf  <= 1'b0;
            end
         end

         if (state == S_DONE) begin
            pend <= 1'b0;
         end else if ((state != S_IDLE) && score_valid) begin
            pend     <= 1'b1;
            pend_val <= score;
         end
      end
   end

   assign pre_tc = (pre == PRE_TC);
   assign wrap   = pre_tc && (idx == IDX_LAST);

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         pre   <= '0;
         idx   <= '0;
         fcnt  <= '0;
         phase <= 1'b1;
      end else begin
         if (pre_tc) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            pre <= pre + 1'b1;
         end

         if (!blink_en) begin
            fcnt  <= '0;
            phase <= 1'b1;
         end else if (wrap) begin
            if (fcnt == FRM_TC) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end
   end

   // zrun walks down from the most significant digit: true while all seen are 0.
   always_comb begin
      cur_dig = '0;
      cur_lz  = 1'b0;
      zrun    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zrun = zrun && (disp[i*4 +: 4] == 4'd0);
         if (idx == IW'(i)) begin
            cur_dig = disp[i*4 +: 4];
            cur_lz  = zrun && (i != 0);
         end
      end
   end

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         seg <= 7'b1111111;
         an  <= '1;
      end else begin
         seg <= (blank_lz && !ovf && cur_lz) ? 7'b1111111 : seg_dec(cur_dig);
         an  <= (blink_en && !phase) ? '1 : ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_score_disp_bcd.sv
// Directed and randomized checks of score_disp_bcd against a decimal
// arithmetic model of what each scanned digit should show.
module tb_score_disp_bcd;
   localparam int ND = 4;
   localparam int SW = 14;
   localparam int RD = 4;
   localparam int BD = 2;

   logic          segclk = 1'b0;
   logic          clr_n = 1'b0;
   logic [SW-1:0] score = '0;
   logic          score_valid = 1'b0;
   logic          blank_lz = 1'b0;
   logic          blink_en = 1'b0;
   logic [6:0]    seg;
   logic [ND-1:0] an;
   logic          busy;
   logic          ovf;

   int total = 0;
   int bad = 0;

   localparam logic [6:0] GL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

   score_disp_bcd #(
      .NUM_DIGITS(ND), .SCORE_W(SW), .REFRESH_DIV(RD), .BLINK_DIV(BD)
   ) dut (
      .segclk(segclk), .clr_n(clr_n), .score(score), .score_valid(score_valid),
      .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .an(an),
      .busy(busy), .ovf(ovf)
   );

   always #5 segclk = ~segclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int pow10(input int n);
      int p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input bit blank, input int i);
      if (v > pow10(ND) - 1) return GL[9];
      if (blank && i > 0 && v < pow10(i)) return 7'b1111111;
      return GL[(v / pow10(i)) % 10];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int v, output int nbusy);
      @(negedge segclk);
      score = SW'(v);
      score_valid = 1'b1;
      @(negedge segclk);
      score_valid = 1'b0;
      nbusy = 0;
      while (busy === 1'b1 && nbusy < 100) begin
         nbusy++;
         @(negedge segclk);
      end
   endtask

   task automatic sync_digit0();
      int k = 0;
      while (an === 4'b1110 && k < 64) begin k++; @(negedge segclk); end
      while (an !== 4'b1110 && k < 128) begin k++; @(negedge segclk); end
      check("sync_digit0", an, 4'b1110);
   endtask

   task automatic check_frame(input string tag, input int v, input bit blank);
      logic [3:0] ea;
      repeat (2) @(negedge segclk);
      check({tag, "_ovf"}, ovf, (v > pow10(ND) - 1));
      sync_digit0();
      for (int i = 0; i < ND; i++) begin
         ea = ~(4'b0001 << i);
         for (int j = 0; j < RD; j++) begin
            check(tag, {an, seg}, {ea, exp_seg(v, blank, i)});
            @(negedge segclk);
         end
      end
   endtask

   task automatic load_and_check(input string tag, input int v, input bit blank);
      int nb;
      blank_lz = blank;
      load(v, nb);
      check({tag, "_busy_len"}, nb, SW + 1);
      check_frame(tag, v, blank);
   endtask

   initial begin
      int nb, v, t5, t7, prevb, fell, gap, saw6, saw9;
      bit b, on;
      logic [3:0] ea;

      repeat (3) @(negedge segclk);
      check("rst_seg", seg, 7'b1111111);
      check("rst_an", an, 4'b1111);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      clr_n = 1'b1;
      @(negedge segclk);
      check("start_an", an, 4'b1110);
      check("start_seg", seg, GL[0]);
      check_frame("zero", 0, 1'b0);

      @(posedge segclk);
      #2 clr_n = 1'b0;
      #1;
      check("async_seg", seg, 7'b1111111);
      check("async_an", an, 4'b1111);
      check("async_busy", busy, 1'b0);
      @(negedge segclk);
      clr_n = 1'b1;

      load_and_check("d1234", 1234, 1'b0);
      load_and_check("d7", 7, 1'b1);
      load_and_check("d0", 0, 1'b1);
      load_and_check("d1005", 1005, 1'b1);
      load_and_check("d12000", 12000, 1'b1);
      load_and_check("d42", 42, 1'b1);
      load_and_check("d9999", 9999, 1'b1);
      load_and_check("d10000", 10000, 1'b0);
      load_and_check("d16383", 16383, 1'b1);
      repeat (8) begin
         v = int'($urandom_range(0, 16383));
         b = 1'($urandom_range(0, 1));
         load_and_check("rand", v, b);
      end

      // back-to-back strobes: 55 converts, 66 is overwritten by 77
      load_and_check("pre0", 0, 1'b0);
      t5 = -1; t7 = -1; prevb = 0; fell = 0; gap = 0; saw6 = 0; nb = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge segclk);
         if (busy === 1'b1) nb++;
         if (prevb == 1 && busy === 1'b0) fell = 1;
         if (fell == 1 && busy === 1'b1) gap = 1;
         prevb = (busy === 1'b1) ? 1 : 0;
         if (an === 4'b1110 || an === 4'b1101) begin
            if (seg === GL[5] && t5 < 0) t5 = k;
            if (seg === GL[7] && t7 < 0) t7 = k;
            if (seg === GL[6]) saw6 = 1;
         end
         score_valid = 1'b0;
         if (k == 0)  begin score = SW'(55); score_valid = 1'b1; end
         if (k == 5)  begin score = SW'(66); score_valid = 1'b1; end
         if (k == 10) begin score = SW'(77); score_valid = 1'b1; end
      end
      check("pend_busy_len", nb, 2 * (SW + 1));
      check("pend_busy_gap", gap, 0);
      check("pend_saw55", (t5 >= 0), 1'b1);
      check("pend_77_after_55", (t7 > t5), 1'b1);
      check("pend_no66", saw6, 0);
      check_frame("pend77", 77, 1'b0);

      load_and_check("pre8", 8, 1'b0);
      sync_digit0();
      blink_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         on = ((f / BD) % 2) == 0;
         for (int j = 0; j < ND * RD; j++) begin
            ea = on ? ~(4'b0001 << (j / RD)) : 4'b1111;
            check("blink_an", an, ea);
            @(negedge segclk);
         end
      end
      blink_en = 1'b0;
      check_frame("unblink", 8, 1'b0);

      load_and_check("pre0b", 0, 1'b0);
      @(negedge segclk);
      score = SW'(999);
      score_valid = 1'b1;
      @(negedge segclk);
      score_valid = 1'b0;
      repeat (4) @(negedge segclk);
      check("r999_busy_pre", busy, 1'b1);
      #2 clr_n = 1'b0;
      #1;
      check("r999_busy", busy, 1'b0);
      check("r999_an", an, 4'b1111);
      @(negedge segclk);
      clr_n = 1'b1;
      saw9 = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge segclk);
         if (seg === GL[9]) saw9 = 1;
      end
      check("r999_never9", saw9, 0);
      check("r999_busy_after", busy, 1'b0);
      check_frame("r999_zero", 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_disp_bcd.md
Name: score_disp_bcd

Overview:
- Parametrised successor to the fixed 4-digit score display.
- Takes a binary score and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes NUM_DIGITS active-low common-anode digits, with leading-zero blanking, overflow saturation and blink.
- Sits between game score logic and board 7-segment pins, clocked by segclk.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; also width of an.
- SCORE_W, 14: width of the binary score input.
- REFRESH_DIV, 65536: segclk cycles each digit stays enabled; must be ≥1.
- BLINK_DIV, 64: full scan frames per blink half-period.

Ports:
- segclk  in  1  system/segment clock; all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- score  in  SCORE_W  binary score, sampled only on score_valid.
- score_valid  in  1  single-cycle load strobe.
- blank_lz  in  1  1 = blank leading zeros.
- blink_en  in  1  1 = flash the whole display.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
- an  out  NUM_DIGITS  anode enables, active-low one-hot, registered.
- busy  out  1  conversion in progress.
- ovf  out  1  last converted score exceeded 10^NUM_DIGITS-1.

Behaviour:
- Reset (clr_n low, asynchronous):
  - seg=7'b1111111, an all ones, busy=0, ovf=0.
  - Display BCD register=0, pending flag=0, scan index=0, prescaler=0, blink phase=on.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: score_valid captures score into the shift register and clears the BCD accumulator (NUM_DIGITS+1 nibbles, the extra nibble detects overflow). Go to SHIFT.
  - SHIFT: runs exactly SCORE_W cycles. Each cycle, add 3 to every accumulator nibble ≥5, then shift left 1, bringing in the score MSB.
  - DONE: one cycle. Copies the low NUM_DIGITS nibbles to the display register atomically, so there is no tearing. If the top nibble ≠0, all display digits load 9 and ovf=1; otherwise ovf=0. Go to IDLE.
- busy=1 in SHIFT and DONE. Latency from score_valid to display register update is SCORE_W+2 cycles.
- score_valid while busy: latch score into a pending register and set pending. A later strobe overwrites it, so only the newest value is kept. On leaving DONE with pending set, go straight to SHIFT with the pending value and clear pending.
- Simultaneous score_valid and DONE: the strobe is treated as pending.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. At terminal count the scan index increments, wrapping NUM_DIGITS-1→0.
  - Index 0 is the rightmost digit (least significant); an[i]=0 only for the active index.
  - seg/an are registered from index and display register, so there is 1-cycle output latency.
- Decode: digits 0-9 use the standard active-low glyphs, e.g. 0=1000000, 1=1111001, 9=0010000. Nibbles 10-15 can never reach the decoder; if one does, decode it as blank (1111111).
- Leading-zero blanking (blank_lz=1): a digit is blanked (seg=1111111, anode still driven) when it and every more-significant digit are 0. Digit 0 is never blanked. blank_lz is ignored when ovf=1.
- Blink:
  - A frame counter increments when index wraps to 0, and toggles the blink phase every BLINK_DIV frames.
  - blink_en=1 with phase off: an all ones.
  - blink_en=0: phase forced on and counter held at 0.
- Reset mid-conversion aborts immediately. There is no partial display update, and the pending value is lost.

Test Plan:
- Reset check, REFRESH_DIV=4: assert clr_n=0 asynchronously mid-cycle → seg=1111111, an=1111, busy=0 immediately. Release → scan of 0000 begins: an=1110, seg=1000000, each digit held 4 cycles.
- Load 1234 (SCORE_W=14): busy high exactly 15 cycles, then sequence an=1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, each 4 cycles, repeating.
- blank_lz=1, load 7 → digit0 seg=1111000, digits1-3 seg=1111111. Load 0 → digit0 seg=1000000, others blank. Load 1005 → 1,0,0,5 all shown.
- Load 12000 → ovf=1, all four digits seg=0010000 even with blank_lz=1. Load 42 → ovf=0, shows 0042.
- Strobe 55, then 66 and 77 while busy → 55 displayed first, 66 dropped, 77 final, busy stays high continuously across both conversions.
- blink_en=1, BLINK_DIV=2 → an all ones for 2 frames, digits for 2 frames, alternating. Assert clr_n=0 during SHIFT of 999 → display 0000, busy=0, no 999 ever shown.
